// File: rtl/frame_pkg.sv
// Shared types and limits for the motion-detector frame store sequencer.
package frame_pkg;

    localparam int unsigned MAX_W = 1280;
    localparam int unsigned MAX_H = 720;
    localparam int unsigned AW    = 20;

    typedef enum logic [1:0] {
        BUF0 = 2'd0,
        BUF1 = 2'd1,
        BUF2 = 2'd2
    } buf_id_t;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDrain,
        StRotate
    } state_e;

    function automatic logic cfg_legal(input logic [10:0] w, input logic [9:0] h,
                                       input int unsigned max_w, input int unsigned max_h);
        return (w != '0) && (32'(w) <= max_w) && (h != '0) && (32'(h) <= max_h);
    endfunction

endpackage

// File: rtl/frame_buf_rotator.sv
// Buffer role registers (write, t-1, t-2) and the saturating history-frame count.
module frame_buf_rotator
    import frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rotate_i,
    input  logic       invalidate_i,
    output buf_id_t    wr_sel_o,
    output buf_id_t    rd_sel1_o,
    output buf_id_t    rd_sel2_o,
    output logic [1:0] hist_cnt_o
);

    buf_id_t    wr_q, wr_d, rd1_q, rd1_d, rd2_q, rd2_d;
    logic [1:0] hist_q, hist_d;

    // Roles only ever shift among themselves, so they stay a permutation of the three buffers.
    always_comb begin
        wr_d   = wr_q;
        rd1_d  = rd1_q;
        rd2_d  = rd2_q;
        hist_d = hist_q;
        if (rotate_i) begin
            wr_d  = rd2_q;
            rd1_d = wr_q;
            rd2_d = rd1_q;
            if (invalidate_i) begin
                hist_d = 2'd0;
            end else if (hist_q != 2'd2) begin
                hist_d = hist_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= BUF0;
            rd1_q  <= BUF1;
            rd2_q  <= BUF2;
            hist_q <= 2'd0;
        end else begin
            wr_q   <= wr_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            hist_q <= hist_d;
        end
    end

    assign wr_sel_o   = wr_q;
    assign rd_sel1_o  = rd1_q;
    assign rd_sel2_o  = rd2_q;
    assign hist_cnt_o = hist_q;

endmodule

// File: rtl/frame_buf_scheduler.sv
// Sequences the three-buffer frame store: pixel write addressing, frame-length checks
// and buffer role rotation at frame end.
module frame_buf_scheduler
    import frame_pkg::*;
#(
    parameter int unsigned MaxW = MAX_W,
    parameter int unsigned MaxH = MAX_H,
    parameter int unsigned Aw   = AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable_i,
    input  logic [10:0]   width_i,
    input  logic [9:0]    height_i,
    input  logic          s_valid_i,
    input  logic          s_last_i,
    output logic          s_ready_o,
    output logic          mem_we_o,
    output logic [Aw-1:0] mem_addr_o,
    output logic [1:0]    wr_sel_o,
    output logic [1:0]    rd_sel1_o,
    output logic [1:0]    rd_sel2_o,
    output logic          pix_valid_o,
    output logic [1:0]    hist_cnt_o,
    output logic          frame_done_o,
    output logic          err_short_o,
    output logic          err_long_o,
    output logic          cfg_err_o
);

    state_e        state_q, state_d;
    logic [Aw-1:0] pix_cnt_q, pix_cnt_d, total_q, total_d, cfg_total;
    logic [Aw:0]   cnt_next;
    logic          cfg_err_q, cfg_err_d, pix_valid_q, pix_valid_d;
    logic          cfg_ok, hs, rotate, invalidate;
    buf_id_t       wr_sel, rd_sel1, rd_sel2;

    // Product formed at 21 bits before narrowing to the address width.
    assign cfg_total = Aw'(21'(width_i) * 21'(height_i));
    assign cfg_ok    = cfg_legal(width_i, height_i, MaxW, MaxH);
    assign cnt_next  = {1'b0, pix_cnt_q} + (Aw + 1)'(1);

    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        total_d      = total_q;
        cfg_err_d    = cfg_err_q;
        s_ready_o    = 1'b0;
        mem_we_o     = 1'b0;
        hs           = 1'b0;
        err_short_o  = 1'b0;
        err_long_o   = 1'b0;
        frame_done_o = 1'b0;
        rotate       = 1'b0;
        invalidate   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    total_d   = cfg_total;
                    cfg_err_d = !cfg_ok;
                    if (cfg_ok) state_d = StActive;
                end
            end
            StActive: begin
                s_ready_o = enable_i;
                hs        = s_valid_i && s_ready_o;
                if (hs) begin
                    if (pix_cnt_q == total_q) begin
                        err_long_o = 1'b1;
                        state_d    = s_last_i ? StRotate : StDrain;
                    end else begin
                        mem_we_o  = 1'b1;
                        pix_cnt_d = cnt_next[Aw-1:0];
                        if (s_last_i) begin
                            err_short_o = cnt_next < {1'b0, total_q};
                            state_d     = StRotate;
                        end
                    end
                end
            end
            StDrain: begin
                s_ready_o = enable_i;
                hs        = s_valid_i && s_ready_o;
                if (hs && s_last_i) state_d = StRotate;
            end
            StRotate: begin
                frame_done_o = 1'b1;
                rotate       = 1'b1;
                pix_cnt_d    = '0;
                if (!cfg_ok) begin
                    cfg_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cfg_err_d = 1'b0;
                    state_d   = StActive;
                    // A new geometry makes the stored history frames incomparable.
                    if (cfg_total != total_q) begin
                        invalidate = 1'b1;
                        total_d    = cfg_total;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pix_valid_d = mem_we_o && (hist_cnt_o == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pix_cnt_q   <= '0;
            total_q     <= '0;
            cfg_err_q   <= 1'b0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            total_q     <= total_d;
            cfg_err_q   <= cfg_err_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    frame_buf_rotator u_rotator (
        .clk          (clk),
        .rst          (rst),
        .rotate_i     (rotate),
        .invalidate_i (invalidate),
        .wr_sel_o     (wr_sel),
        .rd_sel1_o    (rd_sel1),
        .rd_sel2_o    (rd_sel2),
        .hist_cnt_o   (hist_cnt_o)
    );

    assign wr_sel_o    = wr_sel;
    assign rd_sel1_o   = rd_sel1;
    assign rd_sel2_o   = rd_sel2;
    assign mem_addr_o  = pix_cnt_q;
    assign pix_valid_o = pix_valid_q;
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_frame_buf_scheduler.sv
// Self-checking bench for frame_buf_scheduler: write-address scoreboard, config table,
// and hand-written frame sequences for rotation, error and reset corner cases.
module tb_frame_buf_scheduler;
    import frame_pkg::*;

    logic        clk = 1'b0;
    logic        rst, enable_i, s_valid_i, s_last_i;
    logic [10:0] width_i;
    logic [9:0]  height_i;
    logic        s_ready_o, mem_we_o, pix_valid_o, frame_done_o;
    logic        err_short_o, err_long_o, cfg_err_o;
    logic [19:0] mem_addr_o;
    logic [1:0]  wr_sel_o, rd_sel1_o, rd_sel2_o, hist_cnt_o;

    int tests = 0;
    int fails = 0;
    int n_done = 0, n_short = 0, n_long = 0, n_pv = 0, n_we = 0;
    logic [19:0] exp_q[$];

    typedef struct {
        logic [10:0] w;
        logic [9:0]  h;
        logic        exp_err;
        logic        exp_ready;
    } cfg_vec_t;
    cfg_vec_t cfg_tbl[6];

    always #5 clk = ~clk;

    frame_buf_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .width_i      (width_i),
        .height_i     (height_i),
        .s_valid_i    (s_valid_i),
        .s_last_i     (s_last_i),
        .s_ready_o    (s_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .wr_sel_o     (wr_sel_o),
        .rd_sel1_o    (rd_sel1_o),
        .rd_sel2_o    (rd_sel2_o),
        .pix_valid_o  (pix_valid_o),
        .hist_cnt_o   (hist_cnt_o),
        .frame_done_o (frame_done_o),
        .err_short_o  (err_short_o),
        .err_long_o   (err_long_o),
        .cfg_err_o    (cfg_err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Write scoreboard and pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_done_o === 1'b1) n_done++;
        if (err_short_o === 1'b1) n_short++;
        if (err_long_o === 1'b1) n_long++;
        if (pix_valid_o === 1'b1) n_pv++;
        if (mem_we_o === 1'b1) begin
            n_we++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got write at addr %0d, required no write",
                         mem_addr_o);
            end else begin
                check("wr_addr", 32'(mem_addr_o), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready_o), 0);
        check({tag, "_mem_we"}, 32'(mem_we_o), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr_o), 0);
        check({tag, "_wr_sel"}, 32'(wr_sel_o), 0);
        check({tag, "_rd_sel1"}, 32'(rd_sel1_o), 1);
        check({tag, "_rd_sel2"}, 32'(rd_sel2_o), 2);
        check({tag, "_pix_valid"}, 32'(pix_valid_o), 0);
        check({tag, "_hist_cnt"}, 32'(hist_cnt_o), 0);
        check({tag, "_frame_done"}, 32'(frame_done_o), 0);
        check({tag, "_err_short"}, 32'(err_short_o), 0);
        check({tag, "_err_long"}, 32'(err_long_o), 0);
        check({tag, "_cfg_err"}, 32'(cfg_err_o), 0);
    endtask

    task automatic apply_reset(input string tag);
        enable_i  = 1'b0;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        rst       = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_vals(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_pixel(input bit last, input bit wr, input int addr,
                              output logic es, output logic el);
        int waitc;
        waitc     = 0;
        s_valid_i = 1'b1;
        s_last_i  = last;
        if (wr) exp_q.push_back(20'(addr));
        @(negedge clk);
        while (s_ready_o !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (s_ready_o !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got s_ready %0d, required 1", s_ready_o);
        end
        es = err_short_o;
        el = err_long_o;
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic send_frame(input int npix);
        logic es, el;
        for (int i = 0; i < npix; i++) send_pixel(i == npix - 1, 1'b1, i, es, el);
    endtask

    // Call right after the last handshake: checks the ROTATE pulse, then the new roles.
    task automatic end_frame(input string tag, input int wr, input int rd1, input int rd2,
                             input int hist);
        @(negedge clk);
        check({tag, "_frame_done"}, 32'(frame_done_o), 1);
        @(posedge clk);
        #1;
        check({tag, "_wr_sel"}, 32'(wr_sel_o), 32'(wr));
        check({tag, "_rd_sel1"}, 32'(rd_sel1_o), 32'(rd1));
        check({tag, "_rd_sel2"}, 32'(rd_sel2_o), 32'(rd2));
        check({tag, "_hist_cnt"}, 32'(hist_cnt_o), 32'(hist));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1);
    end

    initial begin
        int   d0, s0, l0, pv0, we0;
        int   exp_wr[3]   = '{2, 1, 0};
        int   exp_rd1[3]  = '{0, 2, 1};
        int   exp_rd2[3]  = '{1, 0, 2};
        int   exp_hist[3] = '{1, 2, 2};
        logic es, el;

        cfg_tbl[0] = '{11'd1281, 10'd2,   1'b1, 1'b0};
        cfg_tbl[1] = '{11'd4,    10'd0,   1'b1, 1'b0};
        cfg_tbl[2] = '{11'd0,    10'd2,   1'b1, 1'b0};
        cfg_tbl[3] = '{11'd1280, 10'd721, 1'b1, 1'b0};
        cfg_tbl[4] = '{11'd1280, 10'd720, 1'b0, 1'b1};
        cfg_tbl[5] = '{11'd1,    10'd1,   1'b0, 1'b1};

        width_i  = 11'd4;
        height_i = 10'd2;

        // Three full 4x2 frames: roles cycle, history saturates, pix_valid only in frame 3.
        apply_reset("t1_rst");
        enable_i = 1'b1;
        d0 = n_done;
        s0 = n_short;
        l0 = n_long;
        for (int f = 0; f < 3; f++) begin
            pv0 = n_pv;
            send_frame(8);
            end_frame("t1", exp_wr[f], exp_rd1[f], exp_rd2[f], exp_hist[f]);
            check("t1_pix_valid_cycles", 32'(n_pv - pv0), (f == 2) ? 8 : 0);
        end
        check("t1_frame_done_count", 32'(n_done - d0), 3);
        check("t1_err_short_count", 32'(n_short - s0), 0);
        check("t1_err_long_count", 32'(n_long - l0), 0);
        check("t1_sb_empty", 32'(exp_q.size()), 0);

        // Short frame: last on pixel 5, then a full frame restarting at address 0.
        apply_reset("t2_rst");
        enable_i = 1'b1;
        s0 = n_short;
        send_frame(5);
        end_frame("t2a", 2, 0, 1, 1);
        check("t2_err_short_count", 32'(n_short - s0), 1);
        send_frame(8);
        end_frame("t2b", 1, 2, 0, 2);
        check("t2_err_short_total", 32'(n_short - s0), 1);
        check("t2_sb_empty", 32'(exp_q.size()), 0);

        // Long frame: 11 pixels, only the first 8 written, err_long on pixel 9.
        apply_reset("t3_rst");
        enable_i = 1'b1;
        d0  = n_done;
        l0  = n_long;
        s0  = n_short;
        we0 = n_we;
        for (int i = 0; i < 11; i++) begin
            send_pixel(i == 10, i < 8, i, es, el);
            if (i == 8) check("t3_err_long_at_9", 32'(el), 1);
        end
        end_frame("t3", 2, 0, 1, 1);
        check("t3_err_long_count", 32'(n_long - l0), 1);
        check("t3_frame_done_count", 32'(n_done - d0), 1);
        check("t3_err_short_count", 32'(n_short - s0), 0);
        check("t3_write_count", 32'(n_we - we0), 8);
        check("t3_sb_empty", 32'(exp_q.size()), 0);

        // Enable gap of 3 cycles after pixel 4: no ready, no writes, address held.
        apply_reset("t4_rst");
        enable_i = 1'b1;
        d0  = n_done;
        we0 = n_we;
        for (int i = 0; i < 4; i++) send_pixel(1'b0, 1'b1, i, es, el);
        enable_i  = 1'b0;
        s_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_gap_s_ready", 32'(s_ready_o), 0);
            check("t4_gap_mem_we", 32'(mem_we_o), 0);
            check("t4_gap_mem_addr", 32'(mem_addr_o), 4);
            @(posedge clk);
            #1;
        end
        check("t4_gap_no_rotate", 32'(n_done - d0), 0);
        enable_i  = 1'b1;
        s_valid_i = 1'b0;
        for (int i = 4; i < 8; i++) send_pixel(i == 7, 1'b1, i, es, el);
        end_frame("t4", 2, 0, 1, 1);
        check("t4_frame_done_count", 32'(n_done - d0), 1);
        check("t4_write_count", 32'(n_we - we0), 8);
        check("t4_sb_empty", 32'(exp_q.size()), 0);

        // Configuration legality table, sampled on the first enabled IDLE cycle.
        for (int k = 0; k < 6; k++) begin
            apply_reset("t5_rst");
            width_i  = cfg_tbl[k].w;
            height_i = cfg_tbl[k].h;
            enable_i = 1'b1;
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("t5_cfg_err_%0d", k), 32'(cfg_err_o), 32'(cfg_tbl[k].exp_err));
            check($sformatf("t5_s_ready_%0d", k), 32'(s_ready_o), 32'(cfg_tbl[k].exp_ready));
        end

        // Illegal config held for several cycles, then corrected to 1280x720.
        apply_reset("t5b_rst");
        width_i  = 11'd1281;
        height_i = 10'd2;
        enable_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("t5b_cfg_err_hold", 32'(cfg_err_o), 1);
            check("t5b_s_ready_hold", 32'(s_ready_o), 0);
        end
        width_i  = 11'd1280;
        height_i = 10'd720;
        @(posedge clk);
        #1;
        check("t5b_cfg_err_clear", 32'(cfg_err_o), 0);
        check("t5b_s_ready_active", 32'(s_ready_o), 1);

        // Geometry change 4x2 -> 8x2 late in frame 2, then a mid-frame reset.
        apply_reset("t6_rst");
        width_i  = 11'd4;
        height_i = 10'd2;
        enable_i = 1'b1;
        send_frame(8);
        end_frame("t6a", 2, 0, 1, 1);
        for (int i = 0; i < 7; i++) send_pixel(1'b0, 1'b1, i, es, el);
        width_i = 11'd8;
        send_pixel(1'b1, 1'b1, 7, es, el);
        end_frame("t6b", 1, 2, 0, 0);
        l0 = n_long;
        s0 = n_short;
        send_frame(16);
        end_frame("t6c", 0, 1, 2, 1);
        send_frame(16);
        end_frame("t6d", 2, 0, 1, 2);
        check("t6_err_long_count", 32'(n_long - l0), 0);
        check("t6_err_short_count", 32'(n_short - s0), 0);
        for (int i = 0; i < 5; i++) send_pixel(1'b0, 1'b1, i, es, el);
        check("t6_pre_rst_pix_valid", 32'(pix_valid_o), 1);
        check("t6_pre_rst_mem_addr", 32'(mem_addr_o), 5);
        s_valid_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("t6_midrst");
        check("t6_sb_empty", 32'(exp_q.size()), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        s_valid_i = 1'b0;
        enable_i  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
